// File: rtl/alu_sliced_pkg.sv
// Shared typedefs and defaults for the slice-serial ALU.
package alu_sliced_pkg;

  localparam int ALU_XLEN    = 32;
  localparam int ALU_SLICE_W = 8;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_PLUS_4,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_EQ,
    OP_LT,
    OP_LTU,
    OP_SLL,
    OP_SRL,
    OP_SRA
  } cs_alu_op;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } alu_state_e;

  function automatic logic is_cmp_op(input cs_alu_op op);
    return op inside {OP_EQ, OP_LT, OP_LTU};
  endfunction

  function automatic logic is_shift_op(input cs_alu_op op);
    return op inside {OP_SLL, OP_SRL, OP_SRA};
  endfunction

endpackage

// File: rtl/alu_sliced_slice.sv
// One SLICE_W-wide datapath slice: adder with carry, bitwise logic and a
// slice compare (signed only when the caller says this is the MSB slice).
module alu_slice
  import alu_sliced_pkg::*;
#(
  parameter int SLICE_W = ALU_SLICE_W
) (
  input  cs_alu_op           i_op,
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_carry,
  input  logic               i_signed,
  output logic [SLICE_W-1:0] o_y,
  output logic               o_carry,
  output logic               o_eq,
  output logic               o_lt
);

  logic [SLICE_W:0] w_sum;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_carry};
  assign o_carry = w_sum[SLICE_W];
  assign o_eq    = (i_a == i_b);
  assign o_lt    = i_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

  // Select the slice value: logic ops bypass the adder, everything else takes the sum
  always_comb begin
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = w_sum[SLICE_W-1:0];
    endcase
  end

endmodule

// File: rtl/alu_sliced.sv
// Slice-serial ALU: processes SLICE_W bits per cycle. Arithmetic, logic and
// shifts walk LSB slice first; compares walk MSB slice first and stop on the
// first slice that differs.
module alu_sliced
  import alu_sliced_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int SLICE_W = ALU_SLICE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  cs_alu_op        op_i,
  input  logic            cmp_flip_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            cmp_o
);

  localparam int NSLICE = XLEN / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SH_W   = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

  alu_state_e       r_state;
  cs_alu_op         r_op;
  logic             r_flip;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cmp;
  logic             r_done;
  logic             r_busy;

  logic               w_is_cmp;
  logic               w_is_shift;
  logic               w_last;
  logic [CNT_W-1:0]   w_idx;
  logic [SH_W-1:0]    w_shamt;
  logic [XLEN-1:0]    w_shift_full;
  logic [SLICE_W-1:0] w_a_arr  [NSLICE];
  logic [SLICE_W-1:0] w_b_arr  [NSLICE];
  logic [SLICE_W-1:0] w_sh_arr [NSLICE];
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_b_op;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W-1:0] w_slice_res;
  logic               w_cin;
  logic               w_cout;
  logic               w_eq;
  logic               w_lt;
  logic               w_signed;
  logic               w_decided;
  logic               w_verdict;

  assign w_is_cmp   = is_cmp_op(r_op);
  assign w_is_shift = is_shift_op(r_op);
  assign w_last     = (r_cnt == LAST_IDX);
  // Compares walk from the top slice down; everything else from slice 0 up
  assign w_idx      = w_is_cmp ? (LAST_IDX - r_cnt) : r_cnt;
  assign w_shamt    = r_b[SH_W-1:0];

  // Full-width shift of the latched operand; each cycle one slice of it is taken
  always_comb begin
    case (r_op)
      OP_SLL:  w_shift_full = r_a << w_shamt;
      OP_SRL:  w_shift_full = r_a >> w_shamt;
      OP_SRA:  w_shift_full = $unsigned($signed(r_a) >>> w_shamt);
      default: w_shift_full = r_a;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
      assign w_a_arr[gi]  = r_a[gi*SLICE_W +: SLICE_W];
      assign w_b_arr[gi]  = r_b[gi*SLICE_W +: SLICE_W];
      assign w_sh_arr[gi] = w_shift_full[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign w_a_sl = w_a_arr[w_idx];
  assign w_b_sl = w_b_arr[w_idx];

  // Second adder operand: inverted for SUB, a constant 4 on slice 0 for PLUS_4
  always_comb begin
    w_b_op = w_b_sl;
    if (r_op == OP_SUB) begin
      w_b_op = ~w_b_sl;
    end else if (r_op == OP_PLUS_4) begin
      w_b_op = (r_cnt == '0) ? SLICE_W'(4) : '0;
    end
  end

  assign w_cin    = (r_cnt == '0) ? (r_op == OP_SUB) : r_carry;
  assign w_signed = (r_op == OP_LT) && (r_cnt == '0);

  alu_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .i_op     (r_op),
    .i_a      (w_a_sl),
    .i_b      (w_is_cmp ? w_b_sl : w_b_op),
    .i_carry  (w_cin),
    .i_signed (w_signed),
    .o_y      (w_y),
    .o_carry  (w_cout),
    .o_eq     (w_eq),
    .o_lt     (w_lt)
  );

  assign w_slice_res = w_is_shift ? w_sh_arr[w_idx] : w_y;
  // A differing slice settles the compare; reaching the last slice means all equal
  assign w_decided   = !w_eq || w_last;
  assign w_verdict   = !w_eq ? ((r_op != OP_EQ) && w_lt) : (r_op == OP_EQ);

  // Control FSM, operand latches, carry chain and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_flip   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cmp    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // busy stays up through the done cycle, then drops here
          r_busy <= 1'b0;
          if (start_i && !r_busy && !flush_i) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_op     <= op_i;
            r_flip   <= cmp_flip_i;
            r_a      <= a_i;
            r_b      <= b_i;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cmp    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_cmp    <= 1'b0;
          end else if (w_is_cmp) begin
            if (w_decided) begin
              r_state  <= ST_IDLE;
              r_done   <= 1'b1;
              r_cmp    <= w_verdict ^ r_flip;
              r_result <= {{(XLEN-1){1'b0}}, w_verdict ^ r_flip};
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_result[w_idx*SLICE_W +: SLICE_W] <= w_slice_res;
            r_carry <= w_cout;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign cmp_o    = r_cmp;

endmodule

// File: tb/tb_alu_sliced.sv
// Bench for alu_sliced: word-level reference model with per-cycle compare,
// directed literal checks, randomized traffic, and a SLICE_W=32 instance.
module tb_alu_sliced;
  import alu_sliced_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i, flush_i, cmp_flip_i;
  cs_alu_op    op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o, cmp_o;
  logic [31:0] result_o;

  logic        start1, flip1;
  cs_alu_op    op1;
  logic [31:0] a1, b1;
  logic        busy1, done1, cmp1;
  logic [31:0] result1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  alu_sliced #(.XLEN(32), .SLICE_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .op_i(op_i), .cmp_flip_i(cmp_flip_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .cmp_o(cmp_o)
  );

  alu_sliced #(.XLEN(32), .SLICE_W(32)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .flush_i(1'b0),
    .op_i(op1), .cmp_flip_i(flip1), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .result_o(result1), .cmp_o(cmp1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-level reference: {cmp, result}
  function automatic logic [32:0] ref_res(input cs_alu_op op, input logic flip,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [4:0]  sh;
    sh = b[4:0];
    r  = '0;
    v  = 1'b0;
    case (op)
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_PLUS_4: r = a + 32'd4;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLL:    r = a << sh;
      OP_SRL:    r = a >> sh;
      OP_SRA:    r = $unsigned($signed(a) >>> sh);
      OP_EQ:     v = (a == b);
      OP_LT:     v = ($signed(a) < $signed(b));
      default:   v = (a < b);
    endcase
    if (op inside {OP_EQ, OP_LT, OP_LTU}) begin
      v = v ^ flip;
      return {v, 31'd0, v};
    end
    return {1'b0, r};
  endfunction

  // Cycles from acceptance to done: full walk, or MSB-first first differing slice
  function automatic int ref_lat(input cs_alu_op op, input logic [31:0] a,
                                 input logic [31:0] b, input int ns);
    int          w;
    logic [63:0] mask, sa, sb;
    w = 32 / ns;
    if (!(op inside {OP_EQ, OP_LT, OP_LTU})) return ns + 1;
    mask = (64'd1 << w) - 64'd1;
    for (int j = 1; j <= ns; j++) begin
      sa = ({32'd0, a} >> ((ns - j) * w)) & mask;
      sb = ({32'd0, b} >> ((ns - j) * w)) & mask;
      if (sa != sb) return j + 1;
    end
    return ns + 1;
  endfunction

  // Behavioural model of the main instance, advanced on each clock edge
  bit          m_run = 0, m_done = 0, m_cmp = 0, m_flip = 0;
  logic [31:0] m_res = '0, m_a = '0, m_b = '0;
  logic [32:0] m_pend = '0;
  int          m_rem = 0;
  cs_alu_op    m_op = OP_ADD;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_res = '0; m_cmp = 0; m_rem = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (flush_i) begin
        m_run = 0; m_res = '0; m_cmp = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_run = 0; m_done = 1;
          m_cmp = m_pend[32];
          m_res = m_pend[31:0];
          n_txn++;
          $display("txn %0d op=%s a=%h b=%h flip=%0d result=%h cmp=%0d",
                   n_txn, m_op.name(), m_a, m_b, m_flip, m_res, m_cmp);
        end
      end
    end else if (start_i && !flush_i) begin
      m_run = 1; m_res = '0; m_cmp = 0;
      m_op = op_i; m_a = a_i; m_b = b_i; m_flip = cmp_flip_i;
      m_pend = ref_res(op_i, cmp_flip_i, a_i, b_i);
      m_rem  = ref_lat(op_i, a_i, b_i, 4) - 1;
    end
  end

  // Per-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy_o, m_run || m_done);
      chk("done", done_o, m_done);
      if (!m_run) begin
        chk("result", result_o, m_res);
        chk("cmp", cmp_o, m_cmp);
      end else begin
        chk("cmp_in_flight", cmp_o, 1'b0);
      end
    end
  end

  task automatic start_op(input cs_alu_op op, input logic flip,
                          input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; cmp_flip_i = flip; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_dir(input string name, input cs_alu_op op, input logic flip,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input int el);
    int cyc;
    start_op(op, flip, a, b);
    cyc = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, el);
    chk({name, "_result"}, result_o, er);
    chk({name, "_cmp"}, cmp_o, ec);
  endtask

  task automatic run_wide(input string name, input cs_alu_op op, input logic flip,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec);
    int cyc;
    @(posedge clk); #1;
    start1 = 1'b1; op1 = op; flip1 = flip; a1 = a; b1 = b;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("wide txn %s op=%s a=%h b=%h result=%h cmp=%0d cycles=%0d",
             name, op.name(), a, b, result1, cmp1, cyc);
    chk({name, "_latency"}, cyc, 2);
    chk({name, "_result"}, result1, er);
    chk({name, "_cmp"}, cmp1, ec);
  endtask

  task automatic no_done_for(input string name, input int n);
    bit saw;
    saw = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done_o) saw = 1;
    end
    chk(name, saw, 1'b0);
  endtask

  initial begin
    logic [32:0] r;
    cs_alu_op    rop;
    logic [31:0] ra, rb;
    logic        rf;

    start_i = 0; flush_i = 0; cmp_flip_i = 0; op_i = OP_ADD; a_i = '0; b_i = '0;
    start1 = 0; flip1 = 0; op1 = OP_ADD; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_result", result_o, 32'h0);
    chk("reset_cmp", cmp_o, 1'b0);
    rst_n = 1'b1;
    chk_en = 1;

    run_dir("add_carry", OP_ADD, 0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 0, 5);
    run_dir("sub_wrap", OP_SUB, 0, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 5);
    run_dir("plus4", OP_PLUS_4, 0, 32'h0000_00FE, 32'h0, 32'h0000_0102, 0, 5);
    run_dir("lt_signed", OP_LT, 0, 32'h8000_0000, 32'h1, 32'h1, 1, 2);
    run_dir("ltu", OP_LTU, 0, 32'h8000_0000, 32'h1, 32'h0, 0, 2);
    run_dir("eq_ne", OP_EQ, 0, 32'h1234_5678, 32'h1234_5679, 32'h0, 0, 5);
    run_dir("eq_ne_flip", OP_EQ, 1, 32'h1234_5678, 32'h1234_5679, 32'h1, 1, 5);
    run_dir("eq_same", OP_EQ, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h1, 1, 5);
    run_dir("sra31", OP_SRA, 0, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 5);
    run_dir("sll31", OP_SLL, 0, 32'h1, 32'd31, 32'h8000_0000, 0, 5);
    run_dir("srl0", OP_SRL, 0, 32'hF000_0000, 32'd0, 32'hF000_0000, 0, 5);
    run_dir("xor", OP_XOR, 0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 0, 5);

    // Flush during cycle 2 of an ADD
    start_op(OP_ADD, 0, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 1'b0);
    chk("flush_result", result_o, 32'h0);
    no_done_for("flush_no_done", 8);

    // Second start while busy is ignored
    start_op(OP_ADD, 0, 32'd1, 32'd2);
    start_i = 1'b1; op_i = OP_SUB; a_i = 32'd100; b_i = 32'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    begin
      int cyc;
      cyc = 2;
      while (!done_o && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("busy_start_latency", cyc, 5);
      chk("busy_start_result", result_o, 32'd3);
    end
    no_done_for("busy_start_single_done", 8);

    // Reset in the middle of an operation
    start_op(OP_ADD, 0, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    chk("midrst_result", result_o, 32'h0);
    chk("midrst_cmp", cmp_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_done_for("midrst_no_done", 8);

    // Randomized traffic, judged by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start_i    = ($urandom_range(0, 3) == 0);
      flush_i    = ($urandom_range(0, 40) == 0);
      op_i       = cs_alu_op'($urandom_range(0, 11));
      cmp_flip_i = 1'($urandom_range(0, 1));
      a_i        = $urandom;
      case ($urandom_range(0, 4))
        0:       b_i = a_i;
        1:       b_i = {a_i[31:16], 16'($urandom)};
        2:       b_i = {a_i[31:8], 8'($urandom)};
        3:       b_i = 32'($urandom_range(0, 31));
        default: b_i = $urandom;
      endcase
    end
    @(posedge clk); #1;
    start_i = 0; flush_i = 0;
    repeat (10) @(posedge clk);
    #1;

    // Single-slice build
    run_wide("wide_add_wrap", OP_ADD, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    run_wide("wide_lt", OP_LT, 0, 32'h8000_0000, 32'h1, 32'h1, 1);
    run_wide("wide_eq_same", OP_EQ, 0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h1, 1);
    for (int k = 0; k < 12; k++) begin
      rop = cs_alu_op'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? ra : $urandom;
      rf  = 1'($urandom_range(0, 1));
      r   = ref_res(rop, rf, ra, rb);
      run_wide("wide_rand", rop, rf, ra, rb, r[31:0], r[32]);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
